// File: rtl/cpu_pkg.sv
// Shared definitions for the accumulator CPU: responder state encoding,
// controller opcodes/phases, default widths and a saturating-count helper.
package cpu_pkg;

  localparam int AWIDTH_DEF = 5;
  localparam int DWIDTH_DEF = 8;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_LOAD  = 2'd2
  } resp_state_t;

  localparam logic [2:0] OP_HLT = 3'd0;
  localparam logic [2:0] OP_SKZ = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_LDA = 3'd5;
  localparam logic [2:0] OP_STO = 3'd6;
  localparam logic [2:0] OP_JMP = 3'd7;

  localparam logic [2:0] PH_INST_ADDR = 3'd0;
  localparam logic [2:0] PH_INST_FETCH = 3'd1;
  localparam logic [2:0] PH_INST_LOAD = 3'd2;
  localparam logic [2:0] PH_IDLE = 3'd3;
  localparam logic [2:0] PH_OP_ADDR = 3'd4;
  localparam logic [2:0] PH_OP_FETCH = 3'd5;
  localparam logic [2:0] PH_ALU_OP = 3'd6;
  localparam logic [2:0] PH_STORE = 3'd7;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port word RAM: registered read with read enable, write enable write.
// A read and write to the same address in one cycle returns the old word.
module mem_array
  import cpu_pkg::*;
#(
  parameter int AWIDTH = AWIDTH_DEF,
  parameter int DWIDTH = DWIDTH_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [AWIDTH-1:0] i_addr,
  input  logic              i_re,
  input  logic              i_we,
  input  logic [DWIDTH-1:0] i_wdata,
  output logic [DWIDTH-1:0] o_rdata
);

  localparam int DEPTH = 2 ** AWIDTH;

  logic [DWIDTH-1:0] r_mem [0:DEPTH-1];
  logic [DWIDTH-1:0] r_rdata;

  // read register; holds its value when no read is requested
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= {DWIDTH{1'b0}};
    end else if (i_re) begin
      r_rdata <= r_mem[i_addr];
    end
  end

  // storage array, deliberately left unreset
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/cpu_mem_responder.sv
// Memory-side responder for the accumulator CPU: services rd/wr strobes,
// offers a valid/ready program-load port and flags strobe protocol violations.
module cpu_mem_responder
  import cpu_pkg::*;
#(
  parameter int AWIDTH = AWIDTH_DEF,
  parameter int DWIDTH = DWIDTH_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [AWIDTH-1:0] addr,
  input  logic              rd,
  input  logic              wr,
  input  logic              data_e,
  input  logic [DWIDTH-1:0] data_in,
  output logic [DWIDTH-1:0] data_out,
  output logic              data_valid,
  input  logic              load_en,
  input  logic              load_valid,
  input  logic [AWIDTH-1:0] load_addr,
  input  logic [DWIDTH-1:0] load_data,
  output logic              load_ready,
  output logic              loading,
  input  logic              err_clr,
  output logic              err_conflict,
  output logic              err_wr_nodata,
  output logic [7:0]        wr_count
);

  resp_state_t       r_state;
  logic              r_data_valid;
  logic              r_err_conflict;
  logic              r_err_wr_nodata;
  logic [7:0]        r_wr_count;

  logic              w_in_load;
  logic              w_cpu_rd;
  logic              w_cpu_wr;
  logic              w_cpu_we;
  logic              w_load_we;
  logic              w_viol_conflict;
  logic              w_viol_nodata;
  logic              w_mem_we;
  logic [AWIDTH-1:0] w_mem_addr;
  logic [DWIDTH-1:0] w_mem_wdata;

  // CPU strobes are gated off entirely while the load port owns the RAM
  always_comb begin
    w_in_load       = (r_state == ST_LOAD);
    w_cpu_rd        = !w_in_load && rd;
    w_cpu_wr        = !w_in_load && wr;
    w_cpu_we        = w_cpu_wr && data_e;
    w_load_we       = w_in_load && load_en && load_valid;
    w_viol_conflict = w_cpu_rd && w_cpu_wr;
    w_viol_nodata   = w_cpu_wr && !data_e;
    w_mem_we        = w_cpu_we || w_load_we;
    if (w_in_load) begin
      w_mem_addr  = load_addr;
      w_mem_wdata = load_data;
    end else begin
      w_mem_addr  = addr;
      w_mem_wdata = data_in;
    end
  end

  mem_array #(
    .AWIDTH(AWIDTH),
    .DWIDTH(DWIDTH)
  ) u_mem (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_addr (w_mem_addr),
    .i_re   (w_cpu_rd),
    .i_we   (w_mem_we),
    .i_wdata(w_mem_wdata),
    .o_rdata(data_out)
  );

  // mode FSM: a load request waits in DRAIN until the CPU strobes go quiet
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_RUN;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (load_en) begin
            r_state <= (rd || wr) ? ST_DRAIN : ST_LOAD;
          end
        end
        ST_DRAIN: begin
          if (!load_en) begin
            r_state <= ST_RUN;
          end else if (!rd && !wr) begin
            r_state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (!load_en) begin
            r_state <= ST_RUN;
          end
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end

  // read-valid flag, sticky error flags (set beats clear) and write counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data_valid    <= 1'b0;
      r_err_conflict  <= 1'b0;
      r_err_wr_nodata <= 1'b0;
      r_wr_count      <= 8'd0;
    end else begin
      r_data_valid    <= w_cpu_rd;
      r_err_conflict  <= w_viol_conflict || (r_err_conflict && !err_clr);
      r_err_wr_nodata <= w_viol_nodata || (r_err_wr_nodata && !err_clr);
      if (w_cpu_we) begin
        r_wr_count <= sat_inc8(r_wr_count);
      end
    end
  end

  assign data_valid    = r_data_valid;
  assign loading       = w_in_load;
  assign load_ready    = w_in_load && load_en;
  assign err_conflict  = r_err_conflict;
  assign err_wr_nodata = r_err_wr_nodata;
  assign wr_count      = r_wr_count;

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Self-checking bench for cpu_mem_responder: directed scenarios plus random
// strobes, all compared against a behavioural model of the responder.
module tb_cpu_mem_responder;

  localparam int MODE_RUN   = 0;
  localparam int MODE_DRAIN = 1;
  localparam int MODE_LOAD  = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] addr;
  logic       rd, wr, data_e;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       data_valid;
  logic       load_en, load_valid;
  logic [4:0] load_addr;
  logic [7:0] load_data;
  logic       load_ready, loading;
  logic       err_clr, err_conflict, err_wr_nodata;
  logic [7:0] wr_count;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] m_mem [0:31];
  int         m_mode;
  logic [7:0] m_dout;
  bit         m_dv, m_ec, m_en;
  int         m_cnt;
  logic [7:0] saved_cnt;

  cpu_mem_responder dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .rd(rd), .wr(wr), .data_e(data_e),
    .data_in(data_in), .data_out(data_out), .data_valid(data_valid),
    .load_en(load_en), .load_valid(load_valid), .load_addr(load_addr),
    .load_data(load_data), .load_ready(load_ready), .loading(loading),
    .err_clr(err_clr), .err_conflict(err_conflict), .err_wr_nodata(err_wr_nodata),
    .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = MODE_RUN;
    m_dout = 8'h00;
    m_dv = 1'b0;
    m_ec = 1'b0;
    m_en = 1'b0;
    m_cnt = 0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".data_valid"}, 32'(data_valid), 32'(m_dv));
    chk({tag, ".data_out"}, 32'(data_out), 32'(m_dout));
    chk({tag, ".loading"}, 32'(loading), 32'(m_mode == MODE_LOAD));
    chk({tag, ".load_ready"}, 32'(load_ready), 32'((m_mode == MODE_LOAD) && load_en));
    chk({tag, ".err_conflict"}, 32'(err_conflict), 32'(m_ec));
    chk({tag, ".err_wr_nodata"}, 32'(err_wr_nodata), 32'(m_en));
    chk({tag, ".wr_count"}, 32'(wr_count), 32'(m_cnt));
  endtask

  // Advance one clock: model consumes the inputs present before the edge.
  task automatic cycle(input string tag);
    bit vc, vn, quiet;
    quiet = !rd && !wr;
    vc = 1'b0;
    vn = 1'b0;
    if (m_mode != MODE_LOAD) begin
      m_dv = rd;
      if (rd) m_dout = m_mem[addr];
      vc = rd && wr;
      vn = wr && !data_e;
      if (wr && data_e) begin
        m_mem[addr] = data_in;
        if (m_cnt < 255) m_cnt++;
      end
    end else begin
      m_dv = 1'b0;
      if (load_en && load_valid) m_mem[load_addr] = load_data;
    end
    m_ec = vc || (m_ec && !err_clr);
    m_en = vn || (m_en && !err_clr);
    if (m_mode == MODE_RUN) begin
      if (load_en) m_mode = quiet ? MODE_LOAD : MODE_DRAIN;
    end else if (m_mode == MODE_DRAIN) begin
      if (!load_en) m_mode = MODE_RUN;
      else if (quiet) m_mode = MODE_LOAD;
    end else begin
      if (!load_en) m_mode = MODE_RUN;
    end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic idle_inputs();
    rd = 1'b0; wr = 1'b0; data_e = 1'b0; err_clr = 1'b0;
    load_en = 1'b0; load_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    addr = 5'd0; data_in = 8'd0; load_addr = 5'd0; load_data = 8'd0;
    idle_inputs();
    model_reset();
    #3;
    check_all("reset");
    #9;
    rst_n = 1'b1;
    #4;

    // program load of the whole array
    load_en = 1'b1;
    cycle("enter_load");
    load_valid = 1'b1;
    for (int i = 0; i < 32; i++) begin
      load_addr = 5'(i);
      if (i == 0) load_data = 8'h11;
      else if (i == 1) load_data = 8'h22;
      else if (i == 3) load_data = 8'h07;
      else load_data = 8'($urandom);
      cycle("load_word");
    end
    load_valid = 1'b0;
    load_en = 1'b0;
    #1;
    chk("load_ready_drop", 32'(load_ready), 32'd0);
    cycle("exit_load");

    rd = 1'b1; addr = 5'd1;
    cycle("read1");
    chk("read1_value", 32'(data_out), 32'h22);
    rd = 1'b0;
    cycle("idle");
    chk("valid_drop", 32'(data_valid), 32'd0);

    wr = 1'b1; data_e = 1'b1; addr = 5'd5; data_in = 8'hA5;
    cycle("write5");
    wr = 1'b0; data_e = 1'b0; rd = 1'b1;
    cycle("read5");
    chk("read5_value", 32'(data_out), 32'hA5);
    chk("wr_count_one", 32'(wr_count), 32'd1);

    rd = 1'b0; wr = 1'b1; data_e = 1'b0; data_in = 8'h5A;
    cycle("wr_nodata");
    chk("nodata_flag", 32'(err_wr_nodata), 32'd1);
    wr = 1'b0; rd = 1'b1;
    cycle("read5_again");
    chk("nodata_no_write", 32'(data_out), 32'hA5);
    rd = 1'b0; err_clr = 1'b1;
    cycle("clear");
    chk("nodata_cleared", 32'(err_wr_nodata), 32'd0);
    wr = 1'b1; data_e = 1'b0;
    cycle("clear_vs_set");
    chk("set_wins", 32'(err_wr_nodata), 32'd1);
    err_clr = 1'b0;

    addr = 5'd3; rd = 1'b1; wr = 1'b1; data_e = 1'b1; data_in = 8'h3C;
    cycle("conflict");
    chk("conflict_old", 32'(data_out), 32'h07);
    chk("conflict_flag", 32'(err_conflict), 32'd1);
    wr = 1'b0; data_e = 1'b0;
    cycle("read3");
    chk("conflict_new", 32'(data_out), 32'h3C);

    // drain: load request waits for the strobes to stop
    load_en = 1'b1; addr = 5'd1;
    cycle("drain0");
    addr = 5'd0;
    cycle("drain1");
    chk("drain_not_loading", 32'(loading), 32'd0);
    chk("drain_read_ok", 32'(data_out), 32'h11);
    rd = 1'b0;
    cycle("drain_done");
    chk("drain_loading", 32'(loading), 32'd1);
    chk("drain_ready", 32'(load_ready), 32'd1);
    saved_cnt = wr_count;
    wr = 1'b1; data_e = 1'b1; rd = 1'b1; addr = 5'd9;
    cycle("wr_in_load");
    chk("load_ignores_wr", 32'(wr_count), 32'(saved_cnt));
    chk("load_no_valid", 32'(data_valid), 32'd0);
    idle_inputs();
    cycle("leave_load");

    // randomised strobes
    for (int i = 0; i < 800; i++) begin
      rd = ($urandom_range(2) == 0);
      wr = ($urandom_range(3) == 0);
      data_e = ($urandom_range(4) != 0);
      err_clr = ($urandom_range(7) == 0);
      addr = 5'($urandom);
      data_in = 8'($urandom);
      if ($urandom_range(15) == 0) load_en = !load_en;
      load_valid = 1'($urandom);
      load_addr = 5'($urandom);
      load_data = 8'($urandom);
      cycle("random");
    end
    idle_inputs();
    cycle("post_random");

    for (int i = 0; i < 300; i++) begin
      wr = 1'b1; data_e = 1'b1; addr = 5'($urandom); data_in = 8'($urandom);
      cycle("saturate");
    end
    chk("wr_count_sat", 32'(wr_count), 32'd255);

    wr = 1'b1; data_e = 1'b0; rd = 1'b1;
    cycle("flag_setup");
    idle_inputs();
    load_en = 1'b1;
    cycle("enter_load2");
    load_valid = 1'b1; load_addr = 5'd2; load_data = 8'h99;
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst_loading", 32'(loading), 32'd0);
    chk("rst_load_ready", 32'(load_ready), 32'd0);
    chk("rst_wr_count", 32'(wr_count), 32'd0);
    chk("rst_err_conflict", 32'(err_conflict), 32'd0);
    chk("rst_err_nodata", 32'(err_wr_nodata), 32'd0);
    chk("rst_data_valid", 32'(data_valid), 32'd0);
    chk("rst_data_out", 32'(data_out), 32'd0);
    idle_inputs();
    #10;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_run", 32'(loading), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/cpu_mem_responder.md
Name: cpu_mem_responder

Overview:
- Memory-side responder for the accumulator CPU control interface. Answers the controller's sel/rd/wr/data_e strobes with a single-port word memory: registered reads and strobed writes.
- Provides a valid/ready program-load port so a program can be preloaded while the CPU is held off.
- Sits between the address mux / accumulator data path and the CPU top level. Flags protocol violations seen on the strobes.

Parameters:
- AWIDTH, 5, address width; memory depth is 2**AWIDTH words.
- DWIDTH, 8, data word width.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- addr  in  AWIDTH  address from the PC/IR address mux (selected by the controller's sel).
- rd  in  1  read strobe from controller.
- wr  in  1  write strobe from controller.
- data_e  in  1  controller's data-bus enable; data_in is valid only when high.
- data_in  in  DWIDTH  accumulator write data.
- data_out  out  DWIDTH  registered read data.
- data_valid  out  1  high the cycle after a read was sampled.
- load_en  in  1  request program-load mode.
- load_valid  in  1  load word valid.
- load_addr  in  AWIDTH  load address.
- load_data  in  DWIDTH  load word.
- load_ready  out  1  load handshake ready.
- loading  out  1  high while in LOAD state (the CPU top holds the phase counter).
- err_clr  in  1  synchronous clear of the sticky error flags.
- err_conflict  out  1  sticky flag: rd and wr asserted together.
- err_wr_nodata  out  1  sticky flag: wr asserted without data_e.
- wr_count  out  8  count of CPU writes, saturating at 255.

Behaviour:
- Reset values:
  - state = RUN.
  - data_out = 0, data_valid = 0.
  - load_ready = 0, loading = 0.
  - err_conflict = 0, err_wr_nodata = 0.
  - wr_count = 0.
  - Memory array is not reset; its contents are undefined until written.
- State machine: RUN, DRAIN, LOAD.
  - RUN -> LOAD when load_en=1 and rd=0 and wr=0 in the same cycle.
  - RUN -> DRAIN when load_en=1 and (rd or wr) is high.
  - DRAIN -> LOAD on the first cycle with rd=0 and wr=0. CPU strobes are still serviced while in DRAIN.
  - DRAIN -> RUN if load_en drops first.
  - LOAD -> RUN when load_en=0. load_ready falls in the same cycle (combinational from state and load_en).
- LOAD state:
  - load_ready = 1 and loading = 1.
  - Each cycle with load_valid and load_ready writes mem[load_addr] <= load_data.
  - CPU rd/wr are ignored entirely: no data_valid, no errors, no wr_count change.
- RUN/DRAIN read:
  - When rd=1 at a clock edge: data_out <= mem[addr] and data_valid <= 1. Latency is 1 cycle.
  - When rd=0: data_valid <= 0 and data_out holds its last value.
  - The controller holds rd through consecutive fetch phases; every sampled cycle re-reads the current addr.
- RUN/DRAIN write:
  - When wr=1 and data_e=1: mem[addr] <= data_in, and wr_count increments, saturating at 255.
  - When wr=1 and data_e=0: no write, and err_wr_nodata <= 1.
- Simultaneous rd and wr:
  - err_conflict <= 1.
  - The write proceeds per the write rules.
  - The read returns the pre-write (old) data, i.e. read-before-write.
- err_clr:
  - Clears both sticky flags.
  - If a new violation occurs in the same cycle, the flag is set (set wins over clear).
- Reset asserted mid-write or mid-load: the in-flight write may or may not land. All other state returns to its reset value immediately (asynchronous).

Decomposition:
- Shared package cpu_pkg:
  - state encoding for RUN/DRAIN/LOAD;
  - the opcode and phase localparams used by the controller;
  - default AWIDTH/DWIDTH.
- One natural sub-module: mem_array, a single-port RAM with a registered read and a write-enable write (read-before-write). The FSM, error logic and counter stay in cpu_mem_responder.

Test Plan:
- Load then read: load_en=1; write 0x11 to address 0 and 0x22 to address 1 via valid/ready; drop load_en; pulse rd at addr=1 -> next cycle data_out=0x22, data_valid=1.
- CPU write: addr=5, data_in=0xA5, wr=1, data_e=1 for one cycle; then rd at addr=5 -> data_out=0xA5 and wr_count=1.
- Write without data_e: wr=1, data_e=0 at addr=5 -> mem[5] stays 0xA5 and err_wr_nodata=1. Pulse err_clr -> flag returns to 0.
- Conflict: mem[3]=0x07; rd=1, wr=1, data_e=1, data_in=0x3C at addr=3 -> data_out=0x07, err_conflict=1, and a later read of addr=3 returns 0x3C.
- Drain: raise load_en while rd=1 for 2 more cycles -> loading stays 0 and reads keep completing. loading=1 and load_ready=1 on the cycle after rd falls. CPU wr during LOAD -> wr_count unchanged.
- Saturation and reset: 300 valid CPU writes -> wr_count=255. Assert rst_n=0 asynchronously mid-LOAD -> state=RUN, load_ready=0, wr_count=0, both error flags 0.
